// File: rtl/time_of_day_counter.sv
// Real-time clock core: 1 Hz prescaler, HH:MM:SS counters, button set mode, 7-seg display.
// Optional macro HOURLY_CHIME_EN adds the Led_Chime hourly indicator (tied low otherwise).

module tod_key_debounce #(
  parameter int DEB_CYCLES = 1_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic key,
  output logic press
);
  localparam int CW = $clog2(DEB_CYCLES + 1);

  logic          s1, s2, lvl, lvl_d;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1    <= 1'b1;
      s2    <= 1'b1;
      lvl   <= 1'b1;
      lvl_d <= 1'b1;
      cnt   <= '0;
      press <= 1'b0;
    end else begin
      s1    <= key;
      s2    <= s1;
      lvl_d <= lvl;
      press <= lvl_d & ~lvl;
      // any sample matching the accepted level restarts the stability window
      if (s2 == lvl) begin
        cnt <= '0;
      end else if (cnt == CW'(DEB_CYCLES - 1)) begin
        cnt <= '0;
        lvl <= s2;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end
endmodule

module time_of_day_counter #(
  parameter int CLK_HZ     = 50_000_000,
  parameter int DEB_CYCLES = 1_000_000
) (
  input  logic       clk,
  input  logic       RST_CLK,
  input  logic       SW0,
  input  logic       KEY_H,
  input  logic       KEY_M,
  output logic [7:0] shi,
  output logic [7:0] fen,
  output logic [7:0] miao,
  output logic       tick_1hz,
  output logic [6:0] HEX0,
  output logic [6:0] HEX1,
  output logic [6:0] HEX2,
  output logic [6:0] HEX3,
  output logic       Led_Chime
);
  localparam int PW = $clog2(CLK_HZ + 1);

  logic          sw_s1, set_mode;
  logic [PW-1:0] pcnt;
  logic [1:0]    key_raw, key_ev;  // [0] = hour, [1] = minute
  logic [7:0]    shi_n, fen_n, miao_n;

  always_ff @(posedge clk or negedge RST_CLK) begin
    if (!RST_CLK) begin
      sw_s1    <= 1'b0;
      set_mode <= 1'b0;
    end else begin
      sw_s1    <= SW0;
      set_mode <= sw_s1;
    end
  end

  assign key_raw = {KEY_M, KEY_H};

  for (genvar g = 0; g < 2; g++) begin : g_deb
    tod_key_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb (
      .clk   (clk),
      .rst_n (RST_CLK),
      .key   (key_raw[g]),
      .press (key_ev[g])
    );
  end

  always_ff @(posedge clk or negedge RST_CLK) begin
    if (!RST_CLK) begin
      pcnt     <= '0;
      tick_1hz <= 1'b0;
    end else if (set_mode) begin
      pcnt     <= '0;
      tick_1hz <= 1'b0;
    end else begin
      pcnt     <= (pcnt == PW'(CLK_HZ - 1)) ? '0 : pcnt + PW'(1);
      tick_1hz <= (pcnt == PW'(CLK_HZ - 1));
    end
  end

  // set mode has priority, so a tick registered as the mode flips is dropped
  always_comb begin
    shi_n  = shi;
    fen_n  = fen;
    miao_n = miao;
    if (set_mode) begin
      miao_n = '0;
      if (key_ev[1]) fen_n = (fen == 8'd59) ? 8'd0 : fen + 8'd1;
      if (key_ev[0]) shi_n = (shi == 8'd23) ? 8'd0 : shi + 8'd1;
    end else if (tick_1hz) begin
      if (miao == 8'd59) begin
        miao_n = '0;
        if (fen == 8'd59) begin
          fen_n = '0;
          shi_n = (shi == 8'd23) ? 8'd0 : shi + 8'd1;
        end else begin
          fen_n = fen + 8'd1;
        end
      end else begin
        miao_n = miao + 8'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge RST_CLK) begin
    if (!RST_CLK) begin
      shi  <= '0;
      fen  <= '0;
      miao <= '0;
    end else begin
      shi  <= shi_n;
      fen  <= fen_n;
      miao <= miao_n;
    end
  end

  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'd0:    seg7 = 7'b1000000;
      4'd1:    seg7 = 7'b1111001;
      4'd2:    seg7 = 7'b0100100;
      4'd3:    seg7 = 7'b0110000;
      4'd4:    seg7 = 7'b0011001;
      4'd5:    seg7 = 7'b0010010;
      4'd6:    seg7 = 7'b0000010;
      4'd7:    seg7 = 7'b1111000;
      4'd8:    seg7 = 7'b0000000;
      4'd9:    seg7 = 7'b0010000;
      default: seg7 = 7'b1111111;
    endcase
  endfunction

  always_ff @(posedge clk or negedge RST_CLK) begin
    if (!RST_CLK) begin
      HEX0 <= 7'b1000000;
      HEX1 <= 7'b1000000;
      HEX2 <= 7'b1000000;
      HEX3 <= 7'b1000000;
    end else begin
      HEX0 <= seg7(4'(fen % 8'd10));
      HEX1 <= seg7(4'(fen / 8'd10));
      HEX2 <= seg7(4'(shi % 8'd10));
      HEX3 <= seg7(4'(shi / 8'd10));
    end
  end

`ifdef HOURLY_CHIME_EN
  // evaluated on next-state values so the indicator lines up with the time outputs
  always_ff @(posedge clk or negedge RST_CLK) begin
    if (!RST_CLK) Led_Chime <= 1'b0;
    else          Led_Chime <= !set_mode && (fen_n == 8'd0) && (miao_n < 8'd5);
  end
`else
  assign Led_Chime = 1'b0;
`endif

endmodule

// File: doc/time_of_day_counter.md
# time_of_day_counter

Real-time clock core that produces the current hour, minute and second in binary for the alarm comparator. It sits directly upstream of the alarm block and feeds it `shi`/`fen`. It also drives the HEX3..HEX0 time display and supports manual setting through two debounced pushbuttons. Everything runs in the single `clk` domain; the 1 Hz rate is a one-cycle enable, not a derived clock.

## Interface
- `CLK_HZ`, default 50_000_000: `clk` cycles per second; the prescaler period.
- `DEB_CYCLES`, default 1_000_000: cycles a key level must be stable before it is accepted (20 ms at 50 MHz).
- `clk` input 1: system clock.
- `RST_CLK` input 1: reset, asynchronous, active-low. Clears all state.
- `SW0` input 1: mode select; 1 = set mode, 0 = run. Asynchronous; passes through a 2-flop synchronizer.
- `KEY_H` input 1: hour-set pushbutton, active-low, asynchronous.
- `KEY_M` input 1: minute-set pushbutton, active-low, asynchronous.
- `shi` output 8: current hour, binary, 0..23.
- `fen` output 8: current minute, binary, 0..59.
- `miao` output 8: current second, binary, 0..59.
- `tick_1hz` output 1: one-cycle pulse, once per `CLK_HZ` cycles while running.
- `HEX0`, `HEX1` output 7 each: minute ones and minute tens, active-low 7-segment.
- `HEX2`, `HEX3` output 7 each: hour ones and hour tens, active-low 7-segment.
- `Led_Chime` output 1: hourly chime indicator (see Configuration).

## Operation
- **Prescaler**
  - `pcnt` counts 0..CLK_HZ-1 and then wraps.
  - When `pcnt` == CLK_HZ-1, `tick_1hz` is registered high for the next cycle.
  - In set mode, `pcnt` is held at 0 and `tick_1hz` is 0.
- **Run mode** (synchronized SW0 = 0). The time registers advance on the edge that ends a `tick_1hz` cycle:
  - `miao`+1; at 59 it wraps to 0 and carries to `fen`.
  - `fen`+1; at 59 it wraps to 0 and carries to `shi`.
  - `shi`+1; at 23 it wraps to 0.
  - 23:59:59 goes to 00:00:00 on a single edge.
- **Set mode** (synchronized SW0 = 1):
  - `miao` is forced to 0 and the time is frozen.
  - A KEY_M press event sets `fen` to (fen+1) mod 60, with no carry.
  - A KEY_H press event sets `shi` to (shi+1) mod 24.
  - Simultaneous events both apply on the same edge.
  - Key events in run mode are discarded.
- **Leaving set mode.** Counting restarts from `pcnt`=0. The first `tick_1hz` occurs CLK_HZ cycles after the synchronized SW0 falls.
- **Debounce** (per key)
  - Path: 2-flop synchronizer, then a stability counter, then the accepted level (reset value 1 = released).
  - The accepted level changes only after the synchronized level differs from it for DEB_CYCLES consecutive cycles. Any bounce restarts the count.
  - A press event is a one-cycle pulse on the accepted 1→0 transition. Holding a key yields exactly one event; there is no auto-repeat.
- **Display**
  - The tens and ones digits (value/10, value%10) are decoded each cycle into registered HEX outputs.
  - Encoding: 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000.
  - Any other digit value decodes to blank, 1111111.
- **Reset values**
  - `shi`/`fen`/`miao`=0, `tick_1hz`=0, `pcnt`=0, `Led_Chime`=0.
  - HEX0..HEX3=1000000.
  - Accepted key levels = released.
  - Asserting reset mid-count or mid-debounce aborts immediately; nothing pending survives.

## Timing
- **First tick.** After reset release, `tick_1hz` is high in cycle CLK_HZ, and `miao` reads 1 from cycle CLK_HZ+1.
- **Time outputs.** `shi`/`fen`/`miao` are registers and valid the cycle after the updating edge.
- **HEX outputs** lag the time registers by exactly 1 cycle.
- **Key latency.** From a clean key edge to the `fen`/`shi` update is 2 sync + DEB_CYCLES + 1 event + 1 update cycles.
- **SW0 latency.** SW0 takes effect 2 cycles after it changes. A `tick_1hz` already registered in the cycle the mode flips to set is discarded.

## Configuration
- `HOURLY_CHIME_EN` defined:
  - `Led_Chime` = 1 (registered) while running with `fen`=0 and `miao`<5, i.e. for the first 5 seconds of every hour, including 00:00.
  - It is forced to 0 in set mode.
- Not defined: `Led_Chime` is tied to 0 and no chime logic is synthesized.

## Test plan
- **Reset then run** (CLK_HZ=10)
  - Release reset, run 600 cycles.
  - Required: `tick_1hz` first in cycle 10, then every 10 cycles; `miao`=59 and `fen`=0 after 599 cycles; `fen`=1, `miao`=0 after 600.
- **Midnight wrap**
  - Set 23:59 in set mode, return to run, wait 60 ticks.
  - Required: `shi`=0, `fen`=0, `miao`=0 on the same edge; HEX3..HEX0 = 1000000 one cycle later.
- **Debounce** (DEB_CYCLES=4)
  - In set mode, KEY_M bounces 0/1 every 2 cycles for 20 cycles, then holds 0 for 50 cycles.
  - Required: exactly one event; `fen` 0→1; no further increment while held.
- **Simultaneous keys and wrap**
  - Set `shi`=23, `fen`=59; press KEY_H and KEY_M together.
  - Required: 00:00 with no carry; a key pressed in run mode leaves the time unchanged.
- **Async reset mid-operation**
  - Pulse RST_CLK low for 1 cycle at 12:34:56 with a debounce in progress.
  - Required: all outputs return to reset values immediately; no key event after release.
- **Chime** (`HOURLY_CHIME_EN`)
  - Run from 00:59:58.
  - Required: `Led_Chime` rises as `fen` becomes 0 and falls when `miao` reaches 5. Without the macro, `Led_Chime` stays 0.
